// File: rtl/sumador_pkg.sv
// rtl/sumador_pkg.sv - shared types and defaults for the bit-serial adder
package sumador_pkg;

    typedef enum logic [1:0] {IDLE, SUMA, HECHO} estado_t;

    localparam int ANCHO_DEF = 64;

endpackage

// File: rtl/sumador_1_bit.sv
// rtl/sumador_1_bit.sv - single full-adder cell
module sumador_1_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/sumador_serie_ctrl.sv
// rtl/sumador_serie_ctrl.sv - bit-serial adder, one full-adder cell sequenced LSB first
module sumador_serie_ctrl
    import sumador_pkg::*;
#(
    parameter int WIDTH = ANCHO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] IDX_ULT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] IDX_PEN = CW'(WIDTH - 2);

    estado_t          estado_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CW-1:0]    idx_q;
    logic             carry_q, carry_msb_q;
    logic             in_ready_q, out_valid_q, cout_q, overflow_q;
    logic             bit_s, bit_c;

    sumador_1_bit u_celda (
        .a_i (a_q[idx_q]),
        .b_i (b_q[idx_q]),
        .c_i (carry_q),
        .s_o (bit_s),
        .c_o (bit_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_msb_q <= 1'b0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (estado_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        sum_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        estado_q   <= SUMA;
                    end
                end
                SUMA: begin
                    sum_q[idx_q] <= bit_s;
                    carry_q      <= bit_c;
                    // Carry into the MSB is kept for the signed overflow test.
                    if (idx_q == IDX_PEN) begin
                        carry_msb_q <= bit_c;
                    end
                    if (idx_q == IDX_ULT) begin
                        cout_q      <= bit_c;
                        overflow_q  <= carry_msb_q ^ bit_c;
                        out_valid_q <= 1'b1;
                        estado_q    <= HECHO;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                HECHO: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        estado_q    <= IDLE;
                    end
                end
                default: begin
                    estado_q    <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// tb/tb_sumador_serie_ctrl.sv - scoreboard bench for the bit-serial adder
module tb_sumador_serie_ctrl;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } esperado_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    esperado_t    q[$];
    int           n_chk = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           acc_edge = 0;
    bit           ov_prev = 1'b0;
    bit           rand_mode = 1'b0;
    logic [W-1:0] held;

    sumador_serie_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic esperado_t modelo(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        esperado_t e;
        logic [W:0] t;
        t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.s = t[W-1:0];
        e.c = t[W];
        e.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    // Monitor: latency, stability and scoreboard comparison on each handoff.
    always @(negedge clk) begin
        esperado_t e;
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_edge = cyc + 1;
            if (out_valid) begin
                chk("in_ready_low_while_valid", {63'b0, in_ready}, 64'd0);
                if (!ov_prev) begin
                    chk("latency", W'(cyc - acc_edge), W'(W));
                    held = sum;
                end else begin
                    chk("sum_stable", sum, held);
                end
                if (out_ready) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_result actual=%h required=none", sum);
                    end else begin
                        e = q.pop_front();
                        chk("sum", sum, e.s);
                        chk("cout", {63'b0, cout}, {63'b0, e.c});
                        chk("overflow", {63'b0, overflow}, {63'b0, e.v});
                    end
                end
            end
            ov_prev = out_valid && !out_ready;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n;
        @(posedge clk); #1;
        a = x; b = y; cin = c; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("send_timeout", 64'd1, 64'd0);
        q.push_back(modelo(x, y, c));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
        chk({tag, "_out_valid"}, {63'b0, out_valid}, 64'd0);
        chk({tag, "_sum"}, sum, 64'd0);
        chk({tag, "_cout"}, {63'b0, cout}, 64'd0);
        chk({tag, "_overflow"}, {63'b0, overflow}, 64'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_vals("reset");

        send(64'h1, 64'h1, 1'b0);
        wait_idle();
        chk("sum_1p1", sum, 64'h2);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        wait_idle();
        chk("sum_wrap", sum, 64'h0);
        chk("cout_wrap", {63'b0, cout}, 64'd1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_idle();
        chk("sum_ovf", sum, 64'h8000_0000_0000_0000);
        chk("ovf_set", {63'b0, overflow}, 64'd1);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        wait_idle();
        send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
        wait_idle();

        // Backpressure: result held while new operands are offered.
        out_ready = 1'b0;
        send(64'hDEAD_BEEF_0000_1111, 64'h1111_2222_3333_4444, 1'b0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("hold_timeout", 64'd1, 64'd0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            chk("in_ready_hold", {63'b0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        a = 64'd3; b = 64'd4; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("handoff_in_ready", {63'b0, in_ready}, 64'd1);
        chk("handoff_out_valid", {63'b0, out_valid}, 64'd0);
        q.push_back(modelo(64'd3, 64'd4, 1'b0));
        @(posedge clk); #1;
        chk("accept_after_handoff", {63'b0, in_ready}, 64'd0);
        in_valid = 1'b0;
        wait_idle();
        chk("sum_3p4", sum, 64'd7);

        // Reset during SUMA discards the operation.
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        chk_reset_vals("midreset");
        send(64'h5, 64'hA, 1'b0);
        wait_idle();
        chk("sum_after_reset", sum, 64'hF);

        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        wait_idle();
        rand_mode = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
